// File: rtl/processador_pkg.sv
// Shared definitions for the 8-bit single-cycle processor:
// FSM state encodings, default widths and ALU operation codes.
package processador_pkg;

    localparam int LARGURA_PC_PADRAO   = 8;
    localparam int LARGURA_CONT_PADRAO = 16;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        EXECUTA = 2'b01,
        PARADO  = 2'b10
    } estado_t;

    typedef enum logic [2:0] {
        ULA_SOMA = 3'd0,
        ULA_SUB  = 3'd1,
        ULA_AND  = 3'd2,
        ULA_OR   = 3'd3,
        ULA_XOR  = 3'd4,
        ULA_SLT  = 3'd5,
        ULA_COMP = 3'd6
    } op_ula_t;

endpackage

// File: rtl/unidade_pc_if.sv
// Control/ALU inputs and PC-stage outputs of unidade_pc.
// The master side (control unit) drives controls; the slave is the stage.
interface unidade_pc_if #(
    parameter int LARGURA_PC   = 8,
    parameter int LARGURA_CONT = 16
);
    logic                    iniciar;
    logic                    stall;
    logic                    desvio_beq;
    logic                    desvio_bne;
    logic                    salto;
    logic                    chamada;
    logic                    retorno;
    logic                    parada;
    logic [LARGURA_PC-1:0]   imediato;
    logic [LARGURA_PC-1:0]   alvo;
    logic                    saida_comp;
    logic [LARGURA_PC-1:0]   pc;
    logic                    pc_valido;
    logic [LARGURA_PC-1:0]   link;
    logic [LARGURA_CONT-1:0] contador_instr;
    logic [1:0]              estado;

    modport master (
        output iniciar, stall, desvio_beq, desvio_bne,
        output salto, chamada, retorno, parada,
        output imediato, alvo, saida_comp,
        input  pc, pc_valido, link, contador_instr, estado
    );

    modport slave (
        input  iniciar, stall, desvio_beq, desvio_bne,
        input  salto, chamada, retorno, parada,
        input  imediato, alvo, saida_comp,
        output pc, pc_valido, link, contador_instr, estado
    );
endinterface

// File: rtl/somador_desvio.sv
// Sequential and branch-target adders for the PC stage.
// imediato has the PC width, so its sign extension is the identity.
module somador_desvio #(
    parameter int LARGURA_PC = 8
) (
    input  logic [LARGURA_PC-1:0] pc,
    input  logic [LARGURA_PC-1:0] imediato,
    output logic [LARGURA_PC-1:0] pc_mais1,
    output logic [LARGURA_PC-1:0] pc_desvio
);
    assign pc_mais1  = pc + LARGURA_PC'(1);
    assign pc_desvio = pc_mais1 + imediato;
endmodule

// File: rtl/unidade_pc.sv
// Program counter, branch resolution, call/return link,
// halt control and saturating retired-instruction counter.
module unidade_pc
    import processador_pkg::*;
#(
    parameter int LARGURA_PC   = LARGURA_PC_PADRAO,
    parameter int LARGURA_CONT = LARGURA_CONT_PADRAO,
    parameter int PC_INICIAL   = 0
) (
    input logic         clock,
    input logic         reset_n,
    unidade_pc_if.slave bus
);
    localparam logic [LARGURA_PC-1:0] PC_INI =
        LARGURA_PC'(PC_INICIAL);

    estado_t                 estado_q, estado_d;
    logic [LARGURA_PC-1:0]   pc_q, pc_d;
    logic [LARGURA_PC-1:0]   link_q, link_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic [LARGURA_PC-1:0]   pc_mais1, pc_desvio;
    logic                    tomado;

    somador_desvio #(.LARGURA_PC(LARGURA_PC)) u_somador (
        .pc        (pc_q),
        .imediato  (bus.imediato),
        .pc_mais1  (pc_mais1),
        .pc_desvio (pc_desvio)
    );

    assign tomado = (bus.desvio_beq & bus.saida_comp) |
                    (bus.desvio_bne & ~bus.saida_comp);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            pc_q     <= PC_INI;
            link_q   <= '0;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            link_q   <= link_d;
            cont_q   <= cont_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        link_d   = link_q;
        cont_d   = cont_q;
        case (estado_q)
            OCIOSO: begin
                pc_d = PC_INI;
                if (bus.iniciar) estado_d = EXECUTA;
            end
            EXECUTA: begin
                if (!bus.stall) begin
                    if (cont_q != '1) cont_d = cont_q + 1'b1;
                    if (bus.parada) begin
                        estado_d = PARADO;
                    end else if (bus.retorno) begin
                        pc_d = link_q;
                    end else if (bus.chamada) begin
                        link_d = pc_mais1;
                        pc_d   = bus.alvo;
                    end else if (bus.salto) begin
                        pc_d = bus.alvo;
                    end else if (tomado) begin
                        pc_d = pc_desvio;
                    end else begin
                        pc_d = pc_mais1;
                    end
                end
            end
            PARADO: begin
                if (bus.iniciar) begin
                    estado_d = EXECUTA;
                    pc_d     = PC_INI;
                    link_d   = '0;
                    cont_d   = '0;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign bus.pc             = pc_q;
    assign bus.link           = link_q;
    assign bus.contador_instr = cont_q;
    assign bus.estado         = estado_q;
    assign bus.pc_valido      = (estado_q == EXECUTA);
endmodule

// File: tb/tb_unidade_pc.sv
// Directed self-checking bench for unidade_pc.
// A second instance with a 4-bit counter covers saturation.
module tb_unidade_pc;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    unidade_pc_if #(.LARGURA_PC(8), .LARGURA_CONT(16)) b ();
    unidade_pc_if #(.LARGURA_PC(8), .LARGURA_CONT(4))  s ();

    unidade_pc #(
        .LARGURA_PC(8), .LARGURA_CONT(16), .PC_INICIAL(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(b.slave)
    );

    unidade_pc #(
        .LARGURA_PC(8), .LARGURA_CONT(4), .PC_INICIAL(0)
    ) dut_sat (
        .clock(clock), .reset_n(reset_n), .bus(s.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_ctrl();
        b.iniciar = 0; b.stall = 0; b.desvio_beq = 0;
        b.desvio_bne = 0; b.salto = 0; b.chamada = 0;
        b.retorno = 0; b.parada = 0; b.imediato = '0;
        b.alvo = '0; b.saida_comp = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic jump_to(input logic [7:0] a);
        clear_ctrl();
        b.salto = 1; b.alvo = a;
        tick();
        clear_ctrl();
    endtask

    task automatic restart();
        clear_ctrl();
        reset_n = 0;
        #2;
        reset_n = 1;
        b.iniciar = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic test_reset();
        clear_ctrl();
        reset_n = 0;
        #3;
        checks++;
        if (b.pc !== 8'h00 || b.link !== 8'h00) begin
            errors++;
            $display("FAIL reset_pc_link pc=%h link=%h want 00 00",
                     b.pc, b.link);
        end
        checks++;
        if (b.contador_instr !== 16'd0 || b.estado !== 2'b00 ||
            b.pc_valido !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cnt=%h st=%b v=%b want 0 00 0",
                     b.contador_instr, b.estado, b.pc_valido);
        end
        @(negedge clock);
        reset_n = 1;
        b.salto = 1; b.alvo = 8'h55;
        tick();
        checks++;
        if (b.estado !== 2'b00 || b.pc !== 8'h00) begin
            errors++;
            $display("FAIL idle_ignore st=%b pc=%h want 00 00",
                     b.estado, b.pc);
        end
        clear_ctrl();
        b.iniciar = 1;
        tick();
        clear_ctrl();
        checks++;
        if (b.estado !== 2'b01 || b.pc !== 8'h00 ||
            b.pc_valido !== 1'b1) begin
            errors++;
            $display("FAIL start st=%b pc=%h v=%b want 01 00 1",
                     b.estado, b.pc, b.pc_valido);
        end
        tick();
        checks++;
        if (b.pc !== 8'h01) begin
            errors++;
            $display("FAIL seq1 pc=%h want 01", b.pc);
        end
        tick();
        checks++;
        if (b.pc !== 8'h02 || b.contador_instr !== 16'd2) begin
            errors++;
            $display("FAIL seq2 pc=%h cnt=%0d want 02 2",
                     b.pc, b.contador_instr);
        end
    endtask

    task automatic test_branch();
        jump_to(8'h10);
        b.desvio_beq = 1; b.saida_comp = 1; b.imediato = 8'h05;
        tick();
        checks++;
        if (b.pc !== 8'h16) begin
            errors++;
            $display("FAIL beq_taken pc=%h want 16", b.pc);
        end
        jump_to(8'h10);
        b.desvio_beq = 1; b.saida_comp = 0; b.imediato = 8'h05;
        tick();
        checks++;
        if (b.pc !== 8'h11) begin
            errors++;
            $display("FAIL beq_not_taken pc=%h want 11", b.pc);
        end
        jump_to(8'h10);
        b.desvio_bne = 1; b.saida_comp = 0; b.imediato = 8'hF0;
        tick();
        checks++;
        if (b.pc !== 8'h01) begin
            errors++;
            $display("FAIL bne_taken_neg pc=%h want 01", b.pc);
        end
        jump_to(8'h10);
        b.desvio_bne = 1; b.saida_comp = 1; b.imediato = 8'hF0;
        tick();
        checks++;
        if (b.pc !== 8'h11) begin
            errors++;
            $display("FAIL bne_not_taken pc=%h want 11", b.pc);
        end
        clear_ctrl();
    endtask

    task automatic test_wrap();
        jump_to(8'hFF);
        tick();
        checks++;
        if (b.pc !== 8'h00) begin
            errors++;
            $display("FAIL wrap_seq pc=%h want 00", b.pc);
        end
        jump_to(8'hFE);
        b.desvio_beq = 1; b.saida_comp = 1; b.imediato = 8'h03;
        tick();
        checks++;
        if (b.pc !== 8'h02) begin
            errors++;
            $display("FAIL wrap_branch pc=%h want 02", b.pc);
        end
        clear_ctrl();
    endtask

    task automatic test_call_return();
        jump_to(8'h20);
        b.chamada = 1; b.alvo = 8'h80;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h80 || b.link !== 8'h21) begin
            errors++;
            $display("FAIL call pc=%h link=%h want 80 21",
                     b.pc, b.link);
        end
        tick();
        b.retorno = 1;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h21 || b.link !== 8'h21) begin
            errors++;
            $display("FAIL return pc=%h link=%h want 21 21",
                     b.pc, b.link);
        end
        b.salto = 1; b.chamada = 1; b.alvo = 8'h40;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h40 || b.link !== 8'h22) begin
            errors++;
            $display("FAIL call_over_jump pc=%h link=%h want 40 22",
                     b.pc, b.link);
        end
        b.retorno = 1; b.chamada = 1; b.alvo = 8'h99;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h22 || b.link !== 8'h22) begin
            errors++;
            $display("FAIL ret_over_call pc=%h link=%h want 22 22",
                     b.pc, b.link);
        end
    endtask

    task automatic test_stall_halt();
        restart();
        jump_to(8'h30);
        b.chamada = 1; b.alvo = 8'h30;
        tick();
        clear_ctrl();
        b.stall = 1; b.parada = 1; b.salto = 1; b.alvo = 8'h77;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h30 || b.estado !== 2'b01 ||
            b.contador_instr !== 16'd2 || b.link !== 8'h31) begin
            errors++;
            $display("FAIL stall st=%b pc=%h cnt=%0d l=%h want 01 30 2 31",
                     b.estado, b.pc, b.contador_instr, b.link);
        end
        b.parada = 1;
        tick();
        clear_ctrl();
        checks++;
        if (b.estado !== 2'b10 || b.pc !== 8'h30 ||
            b.pc_valido !== 1'b0 || b.contador_instr !== 16'd3) begin
            errors++;
            $display("FAIL halt st=%b pc=%h v=%b cnt=%0d want 10 30 0 3",
                     b.estado, b.pc, b.pc_valido, b.contador_instr);
        end
        b.salto = 1; b.alvo = 8'h66; b.stall = 1;
        tick();
        tick();
        clear_ctrl();
        checks++;
        if (b.estado !== 2'b10 || b.pc !== 8'h30 ||
            b.contador_instr !== 16'd3) begin
            errors++;
            $display("FAIL halt_hold st=%b pc=%h cnt=%0d want 10 30 3",
                     b.estado, b.pc, b.contador_instr);
        end
        b.iniciar = 1;
        tick();
        clear_ctrl();
        checks++;
        if (b.estado !== 2'b01 || b.pc !== 8'h00 ||
            b.contador_instr !== 16'd0 || b.link !== 8'h00) begin
            errors++;
            $display("FAIL restart st=%b pc=%h cnt=%0d l=%h want 01 00 0 00",
                     b.estado, b.pc, b.contador_instr, b.link);
        end
        b.iniciar = 1;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h01 || b.contador_instr !== 16'd1) begin
            errors++;
            $display("FAIL start_in_exec pc=%h cnt=%0d want 01 1",
                     b.pc, b.contador_instr);
        end
    endtask

    task automatic test_async_reset();
        jump_to(8'h0F);
        b.chamada = 1; b.alvo = 8'h42;
        tick();
        clear_ctrl();
        checks++;
        if (b.pc !== 8'h42 || b.link !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset pc=%h link=%h want 42 10",
                     b.pc, b.link);
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (b.pc !== 8'h00 || b.link !== 8'h00 ||
            b.estado !== 2'b00) begin
            errors++;
            $display("FAIL async_reset pc=%h link=%h st=%b want 00 00 00",
                     b.pc, b.link, b.estado);
        end
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_saturation();
        s.iniciar = 1;
        @(posedge clock);
        #1;
        s.iniciar = 0;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (s.contador_instr !== 4'hE) begin
            errors++;
            $display("FAIL sat_14 cnt=%h want E", s.contador_instr);
        end
        tick();
        checks++;
        if (s.contador_instr !== 4'hF) begin
            errors++;
            $display("FAIL sat_15 cnt=%h want F", s.contador_instr);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (s.contador_instr !== 4'hF || s.pc !== 8'h14) begin
            errors++;
            $display("FAIL sat_20 cnt=%h pc=%h want F 14",
                     s.contador_instr, s.pc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1;
        clear_ctrl();
        s.iniciar = 0; s.stall = 0; s.desvio_beq = 0;
        s.desvio_bne = 0; s.salto = 0; s.chamada = 0;
        s.retorno = 0; s.parada = 0; s.imediato = '0;
        s.alvo = '0; s.saida_comp = 0;
        test_reset();
        test_branch();
        test_wrap();
        test_call_return();
        test_stall_halt();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
